// File: rtl/instr_fetch_unit.sv
// In-order instruction fetch: credit-limited imem requests, response FIFO, redirect flush.
// Optional macro FETCH_STATS_EN adds the fetch_count output.
module instr_fetch_unit #(
  parameter int             N        = 32,
  parameter logic [N-1:0]   RESET_PC = 'h0040_0000,
  parameter int             DEPTH    = 2
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [N-1:0]  imem_req_addr,
  input  logic          imem_rsp_valid,
  input  logic [31:0]   imem_rsp_data,
  input  logic          redirect_valid,
  input  logic [N-1:0]  redirect_pc,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [31:0]   inst_data,
  output logic [N-1:0]  inst_pc,
`ifdef FETCH_STATS_EN
  output logic [31:0]   fetch_count,
`endif
  output logic [N-1:0]  fetch_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 4;

  logic [N-1:0]  r_fetch_pc;
  logic [31:0]   r_fifo_data [DEPTH];
  logic [N-1:0]  r_fifo_pc   [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_count;
  logic [N-1:0]  r_pq [DEPTH];
  logic [AW-1:0] r_pq_wr, r_pq_rd;
  logic [AW:0]   r_outst;
  logic [DW-1:0] r_drop;

  logic w_req_hs, w_push, w_pop, w_drop_rsp, w_credit;

  // Credit covers FIFO entries plus live requests, so every response has a slot.
  assign w_credit   = ({1'b0, r_count} + {1'b0, r_outst}) < (AW+2)'(DEPTH);
  assign imem_req_valid = !reset && !redirect_valid && w_credit;
  assign w_req_hs   = imem_req_valid && imem_req_ready;
  assign w_drop_rsp = imem_rsp_valid && (r_drop != '0);
  assign w_push     = imem_rsp_valid && (r_drop == '0) && !redirect_valid;
  assign w_pop      = inst_valid && inst_ready;

  assign imem_req_addr = r_fetch_pc;
  assign fetch_pc      = r_fetch_pc;
  assign inst_valid    = (r_count != '0);
  assign inst_data     = inst_valid ? r_fifo_data[r_rd] : '0;
  assign inst_pc       = inst_valid ? r_fifo_pc[r_rd]   : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_pq_wr    <= '0;
      r_pq_rd    <= '0;
      r_outst    <= '0;
      r_drop     <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight becomes a drop, minus a response landing now.
      r_fetch_pc <= redirect_pc & ~N'(3);
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_pq_wr    <= '0;
      r_pq_rd    <= '0;
      r_outst    <= '0;
      r_drop     <= r_drop + DW'(r_outst) + DW'(w_req_hs) - DW'(imem_rsp_valid);
    end else begin
      if (w_req_hs) begin
        r_pq_wr    <= r_pq_wr + 1'b1;
        r_fetch_pc <= r_fetch_pc + N'(4);
      end
      if (w_drop_rsp) r_drop <= r_drop - 1'b1;
      if (w_push) begin
        r_wr    <= r_wr + 1'b1;
        r_pq_rd <= r_pq_rd + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_outst <= r_outst + (AW+1)'(w_req_hs) - (AW+1)'(w_push);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_hs) r_pq[r_pq_wr] <= r_fetch_pc;
    if (w_push) begin
      r_fifo_data[r_wr] <= imem_rsp_data;
      r_fifo_pc[r_wr]   <= r_pq[r_pq_rd];
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)      fetch_count <= '0;
    else if (w_pop) fetch_count <= fetch_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: memory model pushes expected {pc,data},
// monitor pops and compares on every consumed head.
module tb_instr_fetch_unit;
  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst_data, inst_pc, fetch_pc;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(.N(32), .RESET_PC(RPC), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc),
`ifdef FETCH_STATS_EN
    .fetch_count(fetch_count),
`endif
    .fetch_pc(fetch_pc)
  );

  typedef struct packed { logic [31:0] pc; logic [31:0] data; } exp_t;
  typedef struct packed { logic [31:0] addr; logic [15:0] ep; } req_t;

  exp_t        sbq[$];
  req_t        memq[$];
  logic [31:0] log_pc[$];
  int          checks = 0, errors = 0, n_pop = 0;
  logic [15:0] epoch = '0;
  bit          rsp_hold = 1'b0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: every consumed head must match the oldest expected entry.
  exp_t mon_e;
  initial forever begin
    @(negedge clk);
    if (reset) n_pop = 0;
    else if (inst_valid && inst_ready) begin
      n_pop++;
      log_pc.push_back(inst_pc);
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_inst actual pc=%h required=none", inst_pc);
      end else begin
        mon_e = sbq.pop_front();
        chk("inst_pc", inst_pc, mon_e.pc);
        chk("inst_data", inst_data, mon_e.data);
      end
    end
  end

  // Memory model: responds in order, tags requests with the redirect epoch and
  // pushes an expectation only for responses the fetch unit must deliver.
  req_t mr;
  exp_t me;
  initial forever begin
    @(posedge clk); #1;
    if (!reset && !rsp_hold && memq.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(memq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    @(negedge clk); #1;
    if (reset) begin
      memq.delete();
      sbq.delete();
    end else begin
      if (imem_rsp_valid) begin
        mr = memq.pop_front();
        if (!redirect_valid && mr.ep == epoch) begin
          me.pc = mr.addr; me.data = memf(mr.addr);
          sbq.push_back(me);
        end
      end
      if (redirect_valid) begin
        sbq.delete();
        epoch++;
      end
      if (imem_req_valid && imem_req_ready) begin
        mr.addr = imem_req_addr; mr.ep = epoch;
        memq.push_back(mr);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(2); reset = 1'b0;
    log_pc.delete();
  endtask

  task automatic wait_log(input int n, input string nm);
    int b = 0;
    while (log_pc.size() < n && b < 100) begin tick(1); b++; end
    if (log_pc.size() < n) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=%0d required=%0d", nm, log_pc.size(), n);
    end
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1; redirect_pc = pc;
    tick(1);
    redirect_valid = 1'b0;
    log_pc.delete();
  endtask

  initial begin
    int n, b;
    tick(2);
    chk("rst_fetch_pc", fetch_pc, RPC);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);

    // Streaming fetch
    reset = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1;
    log_pc.delete();
    wait_log(4, "stream");
    chk("stream_pc0", log_pc[0], 32'h0040_0000);
    chk("stream_pc1", log_pc[1], 32'h0040_0004);
    chk("stream_pc2", log_pc[2], 32'h0040_0008);
    chk("stream_pc3", log_pc[3], 32'h0040_000C);

    // Decode stalled: credit stops after DEPTH requests
    do_reset();
    inst_ready = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) n++;
    end
    @(posedge clk); #2;
    chk("stall_req_count", n, 32'd2);
    chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("stall_fetch_pc", fetch_pc, 32'h0040_0008);
    chk("stall_inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("stall_head_pc", inst_pc, 32'h0040_0000);
    inst_ready = 1'b1;
    wait_log(3, "release");
    chk("release_pc2", log_pc[2], 32'h0040_0008);

    // Redirect with two responses held in memory
    do_reset();
    rsp_hold = 1'b1;
    tick(3);
    chk("hold_req_valid", {31'd0, imem_req_valid}, 32'd0);
    redirect(32'h0040_0100);
    chk("redir_fetch_pc", fetch_pc, 32'h0040_0100);
    rsp_hold = 1'b0;
    wait_log(2, "redir");
    chk("redir_pc0", log_pc[0], 32'h0040_0100);
    chk("redir_pc1", log_pc[1], 32'h0040_0104);

    // Misaligned redirect coinciding with a response
    b = 0;
    while (!imem_rsp_valid && b < 20) begin tick(1); b++; end
    if (!imem_rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_wait_timeout actual=0 required=1");
    end
    redirect(32'h0040_0203);
    chk("misalign_fetch_pc", fetch_pc, 32'h0040_0200);
    wait_log(1, "misalign");
    chk("misalign_pc0", log_pc[0], 32'h0040_0200);

    // Address wrap
    redirect(32'hFFFF_FFFC);
    wait_log(2, "wrap");
    chk("wrap_pc0", log_pc[0], 32'hFFFF_FFFC);
    chk("wrap_pc1", log_pc[1], 32'h0000_0000);

    // Reset with FIFO full
    inst_ready = 1'b0;
    tick(6);
    chk("full_inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("full_req_valid", {31'd0, imem_req_valid}, 32'd0);
`ifdef FETCH_STATS_EN
    chk("fetch_count", fetch_count, n_pop);
`endif
    reset = 1'b1;
    tick(1);
    chk("rst2_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst2_fetch_pc", fetch_pc, RPC);
    chk("rst2_inst_pc", inst_pc, 32'd0);
    chk("rst2_inst_data", inst_data, 32'd0);
`ifdef FETCH_STATS_EN
    chk("rst2_fetch_count", fetch_count, 32'd0);
`endif
    tick(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
